// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Multicycle word memory serving single LW/SW/fetch accesses and
//            masked LM/SM bursts. Each beat waits LATENCY cycles, then
//            transfers one word and reports the register index it belongs to.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        proc_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_burst,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_mask,
    input  logic [15:0] req_wdata,
    input  logic [15:0] beat_wdata,
    output logic        beat_valid,
    output logic [2:0]  beat_idx,
    output logic [15:0] beat_rdata,
    output logic        done
);

    localparam int         c_DEPTH = 1 << ADDR_W;
    localparam logic [2:0] c_LAT   = 3'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic [7:0]          r_mask;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_burst;
    logic [15:0]         r_wdata;
    logic                r_ready;
    logic                r_beat_valid;
    logic                r_done;
    logic [15:0]         r_rdata;
    logic [15:0]         r_mem [c_DEPTH];

    logic [7:0]          w_req_mask;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [7:0]          w_mask_clr;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [2:0]          w_idx;
    logic                w_mem_we;
    logic [15:0]         w_mem_wdata;

    // Upper request address bits are outside the storage and deliberately dropped.
    if (ADDR_W < 16) begin : g_addr_hi
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^req_addr[15:ADDR_W];
    end

    // True when exactly one mask bit is set, i.e. the beat about to run is the last.
    function automatic logic f_single(input logic [7:0] m);
        return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
    endfunction

    // Request decode, next mask/address for the following beat, memory write port.
    always_comb begin
        w_req_mask  = req_burst ? req_mask : 8'b0000_0001;
        w_req_addr  = req_addr[ADDR_W-1:0];
        w_mask_clr  = r_mask & (r_mask - 8'd1);
        w_addr_inc  = r_addr + 1'b1;
        w_mem_we    = (r_state == S_XFER) && r_we;
        w_mem_wdata = r_burst ? beat_wdata : r_wdata;
    end

    // Lowest set bit of the remaining mask names the register of the current beat.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // Transaction sequencer: latency countdown, beat stepping and registered handshakes.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_mask       <= 8'd0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_burst      <= 1'b0;
            r_wdata      <= 16'd0;
            r_ready      <= 1'b0;
            r_beat_valid <= 1'b0;
            r_done       <= 1'b0;
            r_rdata      <= 16'd0;
        end else begin
            r_beat_valid <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_we    <= req_we;
                        r_burst <= req_burst;
                        r_addr  <= w_req_addr;
                        r_wdata <= req_wdata;
                        r_mask  <= w_req_mask;
                        if (w_req_mask == 8'd0) begin
                            r_state <= S_ZERO;
                            r_done  <= 1'b1;
                        end else if (c_LAT == 3'd0) begin
                            r_state      <= S_XFER;
                            r_beat_valid <= 1'b1;
                            r_done       <= f_single(w_req_mask);
                            if (!req_we) begin
                                r_rdata <= r_mem[w_req_addr];
                            end
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_LAT;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 3'd1) begin
                        r_state      <= S_XFER;
                        r_cnt        <= 3'd0;
                        r_beat_valid <= 1'b1;
                        r_done       <= f_single(r_mask);
                        if (!r_we) begin
                            r_rdata <= r_mem[r_addr];
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_XFER: begin
                    r_mask <= w_mask_clr;
                    r_addr <= w_addr_inc;
                    if (w_mask_clr == 8'd0) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else if (c_LAT == 3'd0) begin
                        r_state      <= S_XFER;
                        r_beat_valid <= 1'b1;
                        r_done       <= f_single(w_mask_clr);
                        if (!r_we) begin
                            r_rdata <= r_mem[w_addr_inc];
                        end
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= c_LAT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage write on the edge leaving XFER; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= w_mem_wdata;
        end
    end

    assign req_ready  = r_ready;
    assign beat_valid = r_beat_valid;
    assign beat_idx   = w_idx;
    assign beat_rdata = r_rdata;
    assign done       = r_done;

endmodule
`default_nettype wire
